clint_responder: RTL

CLINT_RESPONDER -- requirements
Module: clint_responder

---
 rtl/clint_responder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/clint_responder.sv
// rtl/clint_responder.sv - machine timer / software interrupt register block
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   ce_i         bus chip enable
//   we_i         1 = write, 0 = read
//   addr_i       byte address; [31:16] must equal BASE_HI, [15:2] pick the register
//   data_i       write data
//   data_o       combinational read data, zero when no read is selected
//   timer_irq_o  registered (mtime >= mtimecmp)
//   soft_irq_o   msip bit0

module clint_responder #(
   parameter int unsigned TICK_DIV = 1,
   parameter logic [15:0] BASE_HI  = 16'h0200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        timer_irq_o,
   output logic        soft_irq_o
);

   // Word offsets (addr_i[15:2]) of the mapped registers.
   localparam logic [13:0] OFF_MSIP     = 14'h0000;  // 0x0000
   localparam logic [13:0] OFF_CMP_LO   = 14'h1000;  // 0x4000
   localparam logic [13:0] OFF_CMP_HI   = 14'h1001;  // 0x4004
   localparam logic [13:0] OFF_MTIME_LO = 14'h2FFE;  // 0xBFF8
   localparam logic [13:0] OFF_MTIME_HI = 14'h2FFF;  // 0xBFFC

   localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        msip;
   logic [15:0] div_cnt;
   logic        timer_irq;

   logic        sel;
   logic        wr;
   logic        rd;
   logic [13:0] off;
   logic        wr_msip;
   logic        wr_cmp_lo;
   logic        wr_cmp_hi;
   logic        wr_mtime_lo;
   logic        wr_mtime_hi;
   logic        tick;

   // Byte-lane bits carry no meaning for 32-bit registers.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr_i[1:0];

   assign sel = ce_i && (addr_i[31:16] == BASE_HI);
   assign wr  = sel && we_i;
   assign rd  = sel && !we_i;
   assign off = addr_i[15:2];

   assign wr_msip     = wr && (off == OFF_MSIP);
   assign wr_cmp_lo   = wr && (off == OFF_CMP_LO);
   assign wr_cmp_hi   = wr && (off == OFF_CMP_HI);
   assign wr_mtime_lo = wr && (off == OFF_MTIME_LO);
   assign wr_mtime_hi = wr && (off == OFF_MTIME_HI);

   assign tick = (div_cnt == DIV_LAST);

   // Divider restarts from zero whenever software rewrites mtime, so the next
   // increment always lands a full TICK_DIV cycles after the write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= 16'd0;
      end else if (wr_mtime_lo || wr_mtime_hi) begin
         div_cnt <= 16'd0;
      end else if (tick) begin
         div_cnt <= 16'd0;
      end else begin
         div_cnt <= div_cnt + 16'd1;
      end
   end

   // A write to either half wins over a coincident tick: the written half
   // takes the bus value, the other half holds, no increment and no carry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime <= 64'd0;
      end else if (wr_mtime_lo) begin
         mtime[31:0] <= data_i;
      end else if (wr_mtime_hi) begin
         mtime[63:32] <= data_i;
      end else if (tick) begin
         mtime <= mtime + 64'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (wr_cmp_lo) begin
         mtimecmp[31:0] <= data_i;
      end else if (wr_cmp_hi) begin
         mtimecmp[63:32] <= data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         msip <= 1'b0;
      end else if (wr_msip) begin
         msip <= data_i[0];
      end
   end

   // Level compare of the current register values; no sticky state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_irq <= 1'b0;
      end else begin
         timer_irq <= (mtime >= mtimecmp);
      end
   end

   always_comb begin
      data_o = 32'h0;
      if (rd) begin
         case (off)
            OFF_MSIP:     data_o = {31'h0, msip};
            OFF_CMP_LO:   data_o = mtimecmp[31:0];
            OFF_CMP_HI:   data_o = mtimecmp[63:32];
            OFF_MTIME_LO: data_o = mtime[31:0];
            OFF_MTIME_HI: data_o = mtime[63:32];
            default:      data_o = 32'h0;
         endcase
      end
   end

   assign timer_irq_o = timer_irq;
   assign soft_irq_o  = msip;

endmodule
